// File: rtl/sam_vram_pkg.sv
// Shared constants and types for the SAM VRAM line fetcher.
package sam_vram_pkg;

    localparam int VRAM_ADDR_W = 19;
    localparam int LINE_LEN_W  = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sam_vram_fifo.sv
// Synchronous show-ahead FIFO holding fetched screen bytes.
// The head entry is presented on dout without a read request; an empty FIFO
// shows all-ones. Flush has priority over push and pop in the same cycle.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module sam_vram_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? {W{1'b1}} : mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; flush empties the queue at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/sam_vram_fetcher.sv
// SAM VRAM line fetcher: during ASIC SRAM turns it walks one scanline of
// screen bytes into a show-ahead FIFO that the pixel serialiser drains.
// Optional build macro VRAM_PAGE_WRAP_EN: the address increments only in
// bits [14:0], so a line wraps inside its 32K page pair.
module sam_vram_fetcher
    import sam_vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = VRAM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  whichturn,
    input  logic                  line_start,
    input  logic [ADDR_W-1:0]     line_base,
    input  logic [LINE_LEN_W-1:0] line_len,
    input  logic [7:0]            data_to_asic,
    output logic [ADDR_W-1:0]     vramaddr,
    input  logic                  pix_rd,
    output logic [7:0]            pix_data,
    output logic                  pix_empty,
    output logic                  busy,
    output logic                  underrun
);

    fetch_state_t          state_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [LINE_LEN_W-1:0] remaining_reg;
    logic                  underrun_reg;
    logic                  fifo_full;
    logic                  slot;
    logic                  fifo_push;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef VRAM_PAGE_WRAP_EN
        logic [14:0] low;
        low = a[14:0] + 15'd1;
        return {a[ADDR_W-1:15], low};
`else
        return a + 1'b1;
`endif
    endfunction

    // A slot is an ASIC turn with room in the FIFO and bytes left to fetch.
    assign slot      = (state_reg == FETCH) && whichturn && !fifo_full &&
                       (remaining_reg != '0);
    assign fifo_push = slot && !line_start;

    assign vramaddr  = addr_reg;
    assign busy      = (state_reg == FETCH);
    assign underrun  = underrun_reg;

    // Fetch control: line_start always wins and restarts the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            underrun_reg  <= 1'b0;
        end else if (line_start) begin
            addr_reg      <= line_base;
            remaining_reg <= line_len;
            underrun_reg  <= 1'b0;
            state_reg     <= (line_len == '0) ? IDLE : FETCH;
        end else begin
            if (pix_rd && pix_empty) underrun_reg <= 1'b1;
            if (slot) begin
                addr_reg      <= next_addr(addr_reg);
                remaining_reg <= remaining_reg - 1'b1;
                if (remaining_reg == LINE_LEN_W'(1)) state_reg <= IDLE;
            end
        end
    end

    sam_vram_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (line_start),
        .push  (fifo_push),
        .din   (data_to_asic),
        .pop   (pix_rd),
        .dout  (pix_data),
        .empty (pix_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_sam_vram_fetcher.sv
// Directed bench for sam_vram_fetcher; SRAM model returns vramaddr[7:0].
module tb_sam_vram_fetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        whichturn;
    logic        line_start;
    logic [18:0] line_base;
    logic [8:0]  line_len;
    logic [7:0]  data_to_asic;
    logic [18:0] vramaddr;
    logic        pix_rd;
    logic [7:0]  pix_data;
    logic        pix_empty;
    logic        busy;
    logic        underrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign data_to_asic = vramaddr[7:0];

    sam_vram_fetcher #(.FIFO_DEPTH(8), .ADDR_W(19)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .whichturn    (whichturn),
        .line_start   (line_start),
        .line_base    (line_base),
        .line_len     (line_len),
        .data_to_asic (data_to_asic),
        .vramaddr     (vramaddr),
        .pix_rd       (pix_rd),
        .pix_data     (pix_data),
        .pix_empty    (pix_empty),
        .busy         (busy),
        .underrun     (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input logic [18:0] base, input logic [8:0] len, input logic wt);
        line_base  = base;
        line_len   = len;
        line_start = 1'b1;
        whichturn  = wt;
        tick();
        line_start = 1'b0;
        whichturn  = 1'b0;
    endtask

    logic [18:0] wrap_exp [4];

    initial begin
        rst_n = 1'b0; whichturn = 1'b0; line_start = 1'b0;
        line_base = '0; line_len = '0; pix_rd = 1'b0;
        tick(); tick();
        check("rst_vramaddr", 32'(vramaddr), 32'h0);
        check("rst_pix_data", 32'(pix_data), 32'hFF);
        check("rst_pix_empty", 32'(pix_empty), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: four-byte line, alternating ASIC turns
        start_line(19'h06000, 9'd4, 1'b0);
        check("t1_busy_start", 32'(busy), 32'h1);
        check("t1_addr_start", 32'(vramaddr), 32'h06000);
        for (int i = 0; i < 8; i++) begin
            whichturn = (i % 2 == 0);
            tick();
            if (i == 0) begin
                check("t1_latency_empty", 32'(pix_empty), 32'h0);
                check("t1_latency_data", 32'(pix_data), 32'h00);
            end
            if (i == 5) check("t1_busy_before_last", 32'(busy), 32'h1);
            if (i == 6) check("t1_busy_after_last", 32'(busy), 32'h0);
            $display("t1 cycle %0d vramaddr=%05h busy=%0b", i, vramaddr, busy);
        end
        whichturn = 1'b0;
        check("t1_addr_end", 32'(vramaddr), 32'h06004);
        for (int k = 0; k < 4; k++) begin
            check("t1_pop_data", 32'(pix_data), 32'(k));
            pix_rd = 1'b1; tick(); pix_rd = 1'b0;
        end
        check("t1_drained_empty", 32'(pix_empty), 32'h1);
        check("t1_drained_data", 32'(pix_data), 32'hFF);
        check("t1_no_underrun", 32'(underrun), 32'h0);

        // 2: sixteen-byte line fills the FIFO, then stalls
        start_line(19'h01000, 9'd16, 1'b0);
        whichturn = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        whichturn = 1'b0;
        $display("t2 after 12 turns vramaddr=%05h", vramaddr);
        check("t2_addr_held", 32'(vramaddr), 32'h01008);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_head", 32'(pix_data), 32'h00);
        pix_rd = 1'b1; tick(); pix_rd = 1'b0;
        check("t2_head_after_pop", 32'(pix_data), 32'h01);
        check("t2_addr_after_pop", 32'(vramaddr), 32'h01008);
        whichturn = 1'b1; tick(); whichturn = 1'b0;
        check("t2_resumed_addr", 32'(vramaddr), 32'h01009);

        // 3: underrun set by reading empty, cleared by line_start
        start_line(19'h00000, 9'd0, 1'b0);
        check("t3_flushed", 32'(pix_empty), 32'h1);
        check("t3_idle", 32'(busy), 32'h0);
        pix_rd = 1'b1; tick(); tick();
        check("t3_underrun_set", 32'(underrun), 32'h1);
        check("t3_empty_kept", 32'(pix_empty), 32'h1);
        pix_rd = 1'b0;
        start_line(19'h00000, 9'd0, 1'b0);
        check("t3_underrun_clr", 32'(underrun), 32'h0);

        // 4: restart mid-fetch with three bytes queued and an ASIC turn
        start_line(19'h02000, 9'd10, 1'b0);
        whichturn = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        whichturn = 1'b0;
        check("t4_queued", 32'(pix_empty), 32'h0);
        check("t4_addr_before", 32'(vramaddr), 32'h02003);
        start_line(19'h03050, 9'd5, 1'b1);
        check("t4_flushed", 32'(pix_empty), 32'h1);
        check("t4_new_addr", 32'(vramaddr), 32'h03050);
        check("t4_busy", 32'(busy), 32'h1);
        whichturn = 1'b1; tick(); whichturn = 1'b0;
        check("t4_first_new_byte", 32'(pix_data), 32'h50);
        check("t4_addr_next", 32'(vramaddr), 32'h03051);

        // 5: address wrap at the top of VRAM
`ifdef VRAM_PAGE_WRAP_EN
        wrap_exp[0] = 19'h7FFFE; wrap_exp[1] = 19'h7FFFF;
        wrap_exp[2] = 19'h78000; wrap_exp[3] = 19'h78001;
`else
        wrap_exp[0] = 19'h7FFFE; wrap_exp[1] = 19'h7FFFF;
        wrap_exp[2] = 19'h00000; wrap_exp[3] = 19'h00001;
`endif
        start_line(19'h7FFFE, 9'd4, 1'b0);
        whichturn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_wrap_addr", 32'(vramaddr), 32'(wrap_exp[i]));
            $display("t5 slot %0d vramaddr=%05h", i, vramaddr);
            tick();
        end
        whichturn = 1'b0;
        check("t5_busy_done", 32'(busy), 32'h0);
        check("t5_final_addr", 32'(vramaddr), 32'(wrap_exp[3] + 19'd1) & 32'h7FFFF);
        for (int k = 0; k < 4; k++) begin
            check("t5_pop_data", 32'(pix_data), 32'(wrap_exp[k][7:0]));
            pix_rd = 1'b1; tick(); pix_rd = 1'b0;
        end

        // 6: asynchronous reset in the middle of a line
        start_line(19'h04000, 9'd8, 1'b0);
        whichturn = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_addr", 32'(vramaddr), 32'h0);
        check("t6_rst_data", 32'(pix_data), 32'hFF);
        check("t6_rst_empty", 32'(pix_empty), 32'h1);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_underrun", 32'(underrun), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        whichturn = 1'b0;
        check("t6_idle_addr", 32'(vramaddr), 32'h0);
        check("t6_idle_empty", 32'(pix_empty), 32'h1);
        check("t6_idle_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
